// File: rtl/reg_pkg.sv
// Shared types for the register-file access front end.
// Address/data widths and the writeback entry layout.
package reg_pkg;

  localparam int REG_ADDR_W = 4;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 16;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_DATA_W-1:0] reg_data_t;

  typedef struct packed {
    reg_addr_t addr;
    reg_data_t data;
  } wb_entry_t;

  typedef struct packed {
    logic      hit;
    reg_data_t data;
  } lookup_t;

  typedef enum logic {
    RS_EMPTY = 1'b0,
    RS_FULL  = 1'b1
  } rs_state_e;

endpackage

// File: rtl/reg_wb_buffer.sv
// In-order writeback FIFO with a two-port associative lookup.
// Lookups return the youngest valid entry matching each index.
module reg_wb_buffer
  import reg_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  wb_entry_t     push_entry_i,
  input  logic          pop_i,
  output logic [CW-1:0] count_o,
  output wb_entry_t     head_o,
  input  reg_addr_t     lk_a_addr_i,
  input  reg_addr_t     lk_b_addr_i,
  output lookup_t       lk_a_o,
  output lookup_t       lk_b_o
);

  wb_entry_t     mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  function automatic logic [PW-1:0] wrap_inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push_i) tail_d = wrap_inc(tail_q);
    if (pop_i)  head_d = wrap_inc(head_q);
    unique case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[tail_q] <= push_entry_i;
  end

  assign count_o = count_q;
  assign head_o  = mem_q[head_q];

  // Walk oldest to youngest so later matches overwrite earlier ones.
  always_comb begin
    logic [PW-1:0] idx;
    lk_a_o = '0;
    lk_b_o = '0;
    idx    = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count_q) begin
        if (mem_q[idx].addr == lk_a_addr_i) begin
          lk_a_o.hit  = 1'b1;
          lk_a_o.data = mem_q[idx].data;
        end
        if (mem_q[idx].addr == lk_b_addr_i) begin
          lk_b_o.hit  = 1'b1;
          lk_b_o.data = mem_q[idx].data;
        end
      end
      idx = wrap_inc(idx);
    end
  end

endmodule

// File: rtl/reg_access_ctrl.sv
// Register-file front end: operand reads with forwarding from a
// buffered writeback queue, and a one-entry response register.
module reg_access_ctrl
  import reg_pkg::*;
#(
  parameter int WB_DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rq_valid,
  output logic      rq_ready,
  input  reg_addr_t rq_rn,
  input  reg_addr_t rq_rm,
  output logic      rs_valid,
  input  logic      rs_ready,
  output reg_data_t rs_rn_data,
  output reg_data_t rs_rm_data,
  input  logic      wb_valid,
  output logic      wb_ready,
  input  reg_addr_t wb_addr,
  input  reg_data_t wb_data,
  input  logic      drain_en,
  output reg_addr_t rf_rn_addr,
  output reg_addr_t rf_rm_addr,
  output reg_addr_t rf_rd_addr,
  output logic      rf_w_en,
  output reg_data_t rf_rd_data,
  input  reg_data_t rf_rn_data,
  input  reg_data_t rf_rm_data
);

  localparam int CW = $clog2(WB_DEPTH + 1);

  logic [CW-1:0] count;
  wb_entry_t     head;
  lookup_t       lk_rn, lk_rm;
  logic          wb_push;
  logic          accept;
  logic          nonempty;

  rs_state_e state_q, state_d;
  reg_data_t rn_q, rn_d;
  reg_data_t rm_q, rm_d;

  assign nonempty = (count != '0);
  assign rf_w_en  = drain_en & nonempty;
  assign wb_ready = (count < CW'(WB_DEPTH)) | rf_w_en;
  assign wb_push  = wb_valid & wb_ready;

  assign rf_rd_addr = nonempty ? head.addr : '0;
  assign rf_rd_data = nonempty ? head.data : '0;
  assign rf_rn_addr = rq_rn;
  assign rf_rm_addr = rq_rm;

  reg_wb_buffer #(
    .DEPTH(WB_DEPTH)
  ) u_wb_buf (
    .clk         (clk),
    .rst         (rst),
    .push_i      (wb_push),
    .push_entry_i('{addr: wb_addr, data: wb_data}),
    .pop_i       (rf_w_en),
    .count_o     (count),
    .head_o      (head),
    .lk_a_addr_i (rq_rn),
    .lk_b_addr_i (rq_rm),
    .lk_a_o      (lk_rn),
    .lk_b_o      (lk_rm)
  );

  assign rq_ready = ~rs_valid | rs_ready;
  assign accept   = rq_valid & rq_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RS_EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RS_EMPTY: if (accept) state_d = RS_FULL;
      RS_FULL:  if (rs_ready & ~rq_valid) state_d = RS_EMPTY;
      default:  state_d = RS_EMPTY;
    endcase
  end

  always_comb begin
    rs_valid = (state_q == RS_FULL);
  end

  // Same-cycle pushes are not in the buffer yet, so reads order first.
  always_comb begin
    rn_d = rn_q;
    rm_d = rm_q;
    if (accept) begin
      rn_d = lk_rn.hit ? lk_rn.data : rf_rn_data;
      rm_d = lk_rm.hit ? lk_rm.data : rf_rm_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rn_q <= '0;
      rm_q <= '0;
    end else begin
      rn_q <= rn_d;
      rm_q <= rm_d;
    end
  end

  assign rs_rn_data = rn_q;
  assign rs_rm_data = rm_q;

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Bench for reg_access_ctrl: architectural register model plus
// pending-write queue; responses checked from a scoreboard queue.
module tb_reg_access_ctrl;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rq_valid, rq_ready;
  logic [3:0]  rq_rn, rq_rm;
  logic        rs_valid, rs_ready;
  logic [31:0] rs_rn_data, rs_rm_data;
  logic        wb_valid, wb_ready;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic        drain_en;
  logic [3:0]  rf_rn_addr, rf_rm_addr, rf_rd_addr;
  logic        rf_w_en;
  logic [31:0] rf_rd_data, rf_rn_data, rf_rm_data;

  always #5 clk = ~clk;

  reg_access_ctrl #(.WB_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .rq_valid  (rq_valid),
    .rq_ready  (rq_ready),
    .rq_rn     (rq_rn),
    .rq_rm     (rq_rm),
    .rs_valid  (rs_valid),
    .rs_ready  (rs_ready),
    .rs_rn_data(rs_rn_data),
    .rs_rm_data(rs_rm_data),
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .drain_en  (drain_en),
    .rf_rn_addr(rf_rn_addr),
    .rf_rm_addr(rf_rm_addr),
    .rf_rd_addr(rf_rd_addr),
    .rf_w_en   (rf_w_en),
    .rf_rd_data(rf_rd_data),
    .rf_rn_data(rf_rn_data),
    .rf_rm_data(rf_rm_data)
  );

  function automatic logic [31:0] init_val(input int i);
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  // Responder register file: combinational read, write at the edge.
  logic [31:0] mem [16];
  assign rf_rn_data = mem[rf_rn_addr];
  assign rf_rm_data = mem[rf_rm_addr];

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = init_val(i);
    forever begin
      @(posedge clk);
      if (rf_w_en) mem[rf_rd_addr] <= rf_rd_data;
    end
  end

  typedef struct {
    logic [31:0] rn;
    logic [31:0] rm;
  } resp_t;

  typedef struct {
    logic [3:0]  a;
    logic [31:0] d;
  } wr_t;

  resp_t       exp_q[$];
  wr_t         pend_q[$];
  logic [31:0] arch [16];
  logic [31:0] committed [16];
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic timeout(input string nm);
    total++;
    bad++;
    $display("FAIL %s: handshake never completed at %0t", nm, $time);
  endtask

  // Response monitor: compares whatever the DUT presents.
  always @(negedge clk) begin
    if (!rst) begin
      chk("rs_valid", 32'(rs_valid), 32'(exp_q.size() != 0));
      chk("rq_ready", 32'(rq_ready),
          32'(exp_q.size() == 0 || rs_ready));
      if (rs_valid && exp_q.size() != 0) begin
        chk("rs_rn_data", rs_rn_data, exp_q[0].rn);
        chk("rs_rm_data", rs_rm_data, exp_q[0].rm);
        if (rs_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Reference model: reads see every accepted older writeback.
  initial begin
    bit wen;
    for (int i = 0; i < 16; i++) begin
      arch[i]      = init_val(i);
      committed[i] = init_val(i);
    end
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        pend_q.delete();
        exp_q.delete();
        arch = committed;
        continue;
      end
      wen = drain_en && pend_q.size() != 0;
      chk("rf_w_en", 32'(rf_w_en), 32'(wen));
      chk("wb_ready", 32'(wb_ready),
          32'(pend_q.size() < DEPTH || wen));
      if (pend_q.size() != 0) begin
        chk("rf_rd_addr", 32'(rf_rd_addr), 32'(pend_q[0].a));
        chk("rf_rd_data", rf_rd_data, pend_q[0].d);
      end else begin
        chk("rf_rd_addr_idle", 32'(rf_rd_addr), 32'd0);
        chk("rf_rd_data_idle", rf_rd_data, 32'd0);
      end
      if (rq_valid && rq_ready)
        exp_q.push_back('{rn: arch[rq_rn], rm: arch[rq_rm]});
      if (wen) begin
        committed[pend_q[0].a] = pend_q[0].d;
        void'(pend_q.pop_front());
      end
      if (wb_valid && wb_ready) begin
        pend_q.push_back('{a: wb_addr, d: wb_data});
        arch[wb_addr] = wb_data;
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wb(input logic [3:0] a, input logic [31:0] d);
    bit ok;
    ok = 1'b0;
    wb_valid = 1'b1;
    wb_addr  = a;
    wb_data  = d;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = wb_ready;
      @(posedge clk);
      #1;
    end
    wb_valid = 1'b0;
    if (!ok) timeout("wb_accept");
  endtask

  task automatic rd(input logic [3:0] n, input logic [3:0] m);
    bit ok;
    ok = 1'b0;
    rq_valid = 1'b1;
    rq_rn    = n;
    rq_rm    = m;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = rq_ready;
      @(posedge clk);
      #1;
    end
    rq_valid = 1'b0;
    if (!ok) timeout("rq_accept");
  endtask

  initial begin
    rq_valid = 0; rq_rn = 0; rq_rm = 0;
    rs_ready = 1; wb_valid = 0; wb_addr = 0;
    wb_data = 0; drain_en = 1;
    cyc(3);
    rst = 1'b0;
    chk("post_rst_rq_ready", 32'(rq_ready), 32'd1);
    chk("post_rst_wb_ready", 32'(wb_ready), 32'd1);
    chk("post_rst_rs_valid", 32'(rs_valid), 32'd0);
    chk("post_rst_rf_w_en", 32'(rf_w_en), 32'd0);
    chk("post_rst_rs_rn", rs_rn_data, 32'd0);

    // Write then read, then a full sweep of all registers.
    wb(4'd3, 32'h0000_00A5);
    cyc(3);
    rd(4'd3, 4'd0);
    cyc(2);
    for (int i = 0; i < 16; i++) wb(4'(i), 32'(i));
    for (int i = 0; i < 16; i++) rd(4'(i), 4'(15 - i));
    cyc(4);

    // Forwarding while draining is frozen.
    drain_en = 1'b0;
    wb(4'd5, 32'h11);
    wb(4'd5, 32'h22);
    rd(4'd5, 4'd5);
    cyc(3);
    drain_en = 1'b1;
    cyc(4);

    // Full buffer: fifth push accepted the cycle drain resumes.
    drain_en = 1'b0;
    for (int i = 0; i < DEPTH; i++) wb(4'(8 + i), 32'h100 + 32'(i));
    wb_valid = 1'b1;
    wb_addr  = 4'd12;
    wb_data  = 32'h1FF;
    cyc(2);
    drain_en = 1'b1;
    wb(4'd12, 32'h1FF);
    drain_en = 1'b0;
    cyc(2);
    drain_en = 1'b1;
    cyc(6);

    // Read and push of the same register in one cycle.
    wb(4'd7, 32'h1);
    cyc(3);
    rq_valid = 1'b1; rq_rn = 4'd7; rq_rm = 4'd7;
    wb_valid = 1'b1; wb_addr = 4'd7; wb_data = 32'h2;
    cyc(1);
    rq_valid = 1'b0;
    wb_valid = 1'b0;
    rd(4'd7, 4'd7);
    cyc(3);

    // Response backpressure with a second read waiting.
    rs_ready = 1'b0;
    rd(4'd1, 4'd2);
    rq_valid = 1'b1; rq_rn = 4'd3; rq_rm = 4'd4;
    cyc(3);
    rs_ready = 1'b1;
    rd(4'd3, 4'd4);
    cyc(3);

    // Randomized traffic over a narrow index range.
    for (int c = 0; c < 400; c++) begin
      rq_valid = 1'($urandom % 2);
      rq_rn    = 4'($urandom_range(0, 3));
      rq_rm    = 4'($urandom_range(0, 3));
      wb_valid = 1'($urandom % 2);
      wb_addr  = 4'($urandom_range(0, 3));
      wb_data  = $urandom;
      drain_en = ($urandom % 4) != 0;
      rs_ready = ($urandom % 3) != 0;
      cyc(1);
    end
    rq_valid = 0; wb_valid = 0;
    drain_en = 1; rs_ready = 1;
    cyc(8);

    // Reset with buffered writes and a held response.
    drain_en = 1'b0;
    wb(4'd2, 32'hDEAD_0002);
    wb(4'd6, 32'hDEAD_0006);
    wb(4'd9, 32'hDEAD_0009);
    rs_ready = 1'b0;
    rd(4'd6, 4'd9);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_rs_valid", 32'(rs_valid), 32'd0);
    chk("rst_rs_rn", rs_rn_data, 32'd0);
    chk("rst_rs_rm", rs_rm_data, 32'd0);
    chk("rst_rf_w_en", 32'(rf_w_en), 32'd0);
    chk("rst_rf_rd_addr", 32'(rf_rd_addr), 32'd0);
    chk("rst_rf_rd_data", rf_rd_data, 32'd0);
    chk("rst_wb_ready", 32'(wb_ready), 32'd1);
    cyc(2);
    rst = 1'b0;
    drain_en = 1'b1;
    rs_ready = 1'b1;
    cyc(5);
    rd(4'd6, 4'd9);
    rd(4'd2, 4'd2);

    // Let everything drain before the summary.
    begin
      bit done;
      done = 1'b0;
      for (int k = 0; k < 50 && !done; k++) begin
        cyc(1);
        done = (exp_q.size() == 0) && (pend_q.size() == 0);
      end
      if (!done) timeout("final_drain");
    end
    cyc(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
